// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the four-requester round-robin arbiter.
//   - N_REQ / SEL_W : requester count and select width (tied to the 4:1 mux)
//   - arb_state_t   : arbiter FSM states
//   - req_vec_t     : one bit per requester
//   - onehot()      : owner index -> one-hot grant vector
//   - sat_inc8()    : 8-bit saturating increment for per-requester grant counters
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int GCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic req_vec_t onehot(input sel_t idx);
    return req_vec_t'(1) << idx;
  endfunction

  function automatic logic [GCNT_W-1:0] sat_inc8(input logic [GCNT_W-1:0] v);
    return (v == {GCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational rotate-and-priority-encode. Starting at ptr and walking upward
//   (wrapping 3 -> 0), returns the first requester with its bit set.
//   Ports:
//     req [3:0] in   request vector
//     ptr [1:0] in   highest-priority position for this evaluation
//     any       out  at least one request is set
//     idx [1:0] out  chosen requester (equals ptr when any=0)
// -----------------------------------------------------------------------------
module rr_pick4
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output logic     any,
  output sel_t     idx
);

  sel_t cand;

  // Walk from the lowest rotated priority to the highest so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//   Four-requester round-robin arbiter with a tenure limit. The registered
//   sel drives the select of the downstream 4:1 mux and is held for the whole
//   tenure of an owner. Every grant is followed by one IDLE bubble cycle.
//
//   Parameters:
//     MAX_HOLD  maximum grant tenure in cycles (>= 1) before forced release
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     req  [3:0] in   request lines, bit i = requester i
//     done       in   current owner ends its transfer
//     gnt  [3:0] out  one-hot grant (registered)
//     sel  [1:0] out  owner index, mux select (registered, held through IDLE)
//     gnt_valid  out  a grant is held (equals |gnt)
//     busy       out  FSM is in GRANT
//
//   Optional build macro ARB_GRANT_CNT_EN:
//     grant_cnt [31:0] out  four packed 8-bit saturating grant counters,
//                           bits [8i+7:8i] count IDLE->GRANT transitions of
//                           requester i.
// -----------------------------------------------------------------------------
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        done,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic        gnt_valid,
  output logic        busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [31:0] grant_cnt
`endif
);

  // Width holds MAX_HOLD-1; the counter is cleared before it could ever wrap.
  localparam int               CNT_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q,     state_d;
  req_vec_t         gnt_q,       gnt_d;
  sel_t             sel_q,       sel_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             busy_q,      busy_d;
  sel_t             rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic pick_any;
  sel_t pick_idx;
  logic release_now;

  rr_pick4 u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Any combination of the three release causes is one release event.
  assign release_now = done | ~req[sel_q] | (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    gnt_valid_d = gnt_valid_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          gnt_d       = onehot(pick_idx);
          sel_d       = pick_idx;
          gnt_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
        end
      end

      GRANT: begin
        if (release_now) begin
          // sel is intentionally left alone so the mux keeps its last input.
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          busy_d      = 1'b0;
          rr_ptr_d    = sel_q + 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = busy_q;

`ifdef ARB_GRANT_CNT_EN
  logic [N_REQ-1:0][GCNT_W-1:0] gcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= '0;
    end else if (state_q == IDLE && pick_any) begin
      gcnt_q[pick_idx] <= sat_inc8(gcnt_q[pick_idx]);
    end
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       gnt_valid;
  logic       busy;
`ifdef ARB_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        vld;
    logic        busy;
    logic [31:0] gc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  bit m_busy;
  int m_sel, m_ptr, m_ten;
  int m_gc[4];

  logic [3:0] hist_g[MH+2];

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .busy      (busy)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 0;
      m_ten  = 0;
      for (int i = 0; i < 4; i++) m_gc[i] = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (req[c]) begin
          m_busy = 1'b1;
          m_sel  = c;
          m_ten  = 0;
          if (m_gc[c] < 255) m_gc[c]++;
          break;
        end
      end
    end else if (done || !req[m_sel] || m_ten == MH - 1) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % 4;
    end else begin
      m_ten++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = m_busy ? 4'(1 << m_sel) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.vld  = m_busy;
    e.busy = m_busy;
    e.gc   = {8'(m_gc[3]), 8'(m_gc[2]), 8'(m_gc[1]), 8'(m_gc[0])};
    return e;
  endfunction

  task automatic step();
    exp_t e;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb.gnt", {28'b0, gnt}, {28'b0, e.gnt});
    chk("sb.sel", {30'b0, sel}, {30'b0, e.sel});
    chk("sb.gnt_valid", {31'b0, gnt_valid}, {31'b0, e.vld});
    chk("sb.busy", {31'b0, busy}, {31'b0, e.busy});
`ifdef ARB_GRANT_CNT_EN
    chk("sb.grant_cnt", grant_cnt, e.gc);
`endif
  endtask

  initial begin
    int run;
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // Reset with all requesting, then first grants
    step();
    step();
    chk("A.rst_gnt", {28'b0, gnt}, 32'h0);
    chk("A.rst_sel", {30'b0, sel}, 32'h0);
    chk("A.rst_valid", {31'b0, gnt_valid}, 32'h0);
    chk("A.rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    step();
    chk("A.first_gnt", {28'b0, gnt}, 32'b0001);
    chk("A.first_sel", {30'b0, sel}, 32'd0);
    done = 1'b1;
    step();
    chk("A.bubble", {28'b0, gnt}, 32'h0);
    chk("A.bubble_sel", {30'b0, sel}, 32'd0);
    done = 1'b0;
    step();
    chk("A.second_gnt", {28'b0, gnt}, 32'b0010);
    chk("A.second_sel", {30'b0, sel}, 32'd1);

    // Forced release after MAX_HOLD cycles
    rst = 1'b1;
    req = 4'b0100;
    step();
    rst = 1'b0;
    for (int i = 0; i < MH + 2; i++) begin
      step();
      hist_g[i] = gnt;
    end
    run = 0;
    for (int i = 0; i < MH + 2; i++)
      if (hist_g[i] == 4'b0100 && run == i) run++;
    chk("B.tenure", 32'(run), 32'(MH));
    chk("B.bubble", {28'b0, hist_g[MH]}, 32'h0);
    chk("B.regrant", {28'b0, hist_g[MH+1]}, 32'b0100);
    chk("B.regrant_sel", {30'b0, sel}, 32'd2);

    // Owner drops its request on its third grant cycle
    rst = 1'b1;
    req = 4'b0010;
    step();
    rst = 1'b0;
    step();
    chk("C.own1", {28'b0, gnt}, 32'b0010);
    req = 4'b1011;
    step();
    step();
    chk("C.own1_c3", {28'b0, gnt}, 32'b0010);
    req = 4'b1001;
    step();
    chk("C.bubble", {28'b0, gnt}, 32'h0);
    step();
    chk("C.next_gnt", {28'b0, gnt}, 32'b1000);
    chk("C.next_sel", {30'b0, sel}, 32'd3);

    // Simultaneous done, request drop and tenure limit
    rst = 1'b1;
    req = 4'b0001;
    step();
    rst = 1'b0;
    step();
    repeat (MH - 1) step();
    chk("D.last_cycle", {28'b0, gnt}, 32'b0001);
    done = 1'b1;
    req  = 4'b1110;
    step();
    chk("D.release", {28'b0, gnt}, 32'h0);
    done = 1'b0;
    step();
    chk("D.ptr_plus1", {30'b0, sel}, 32'd1);

    // Reset in the middle of a grant to requester 3
    rst = 1'b1;
    req = 4'b1000;
    step();
    rst = 1'b0;
    step();
    step();
    chk("E.own3", {30'b0, sel}, 32'd3);
    rst = 1'b1;
    step();
    chk("E.rst_gnt", {28'b0, gnt}, 32'h0);
    chk("E.rst_sel", {30'b0, sel}, 32'd0);
    chk("E.rst_valid", {31'b0, gnt_valid}, 32'h0);
    chk("E.rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("E.ptr_reset", {28'b0, gnt}, 32'b0001);

    // All four requesting continuously: rotation 0,1,2,3,0 with forced release
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("F.rotate", {30'b0, sel}, 32'(g % 4));
      repeat (MH) step();
    end

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      step();
    end
    rst  = 1'b0;
    done = 1'b0;

`ifdef ARB_GRANT_CNT_EN
    // Saturation of requester 0 grant counter
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
      step();
    end
    chk("G.sat", grant_cnt, 32'h0000_00FF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
